// File: rtl/pc_ir_unit.sv
// rtl/pc_ir_unit.sv - multicycle PC/IR/MDR/ALUOut register front end with debug counters
module pc_ir_unit #(
    parameter int                DATA_W   = 32,
    parameter int                JADDR_W  = 26,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              BEQ_BNE,
    input  logic [1:0]        PCSource,
    input  logic              IRWrite,
    input  logic              IorD,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        Op,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] alu_out,
    output logic              pc_load,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  branch_taken_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        FETCHED
    } seq_state_t;

    seq_state_t        seq_state;
    seq_state_t        seq_state_nxt;
    logic              branch_taken;
    logic [DATA_W-1:0] next_pc;

    assign branch_taken = PCWriteCond & (alu_zero ^ BEQ_BNE);
    assign pc_load      = PCWrite | branch_taken;
    assign mem_addr     = IorD ? alu_out : pc;
    assign Op           = ir[DATA_W-1:DATA_W-6];

    // Next-PC source select; the jump target keeps the upper PC bits and truncates
    always_comb begin
        next_pc = pc;
        case (PCSource)
            2'b00:   next_pc = alu_result;
            2'b01:   next_pc = alu_out;
            2'b10:   next_pc = {pc[DATA_W-1:JADDR_W], ir[JADDR_W-1:0]};
            default: next_pc = pc;
        endcase
    end

    // Architectural registers: PC on pc_load, IR on IRWrite, MDR/ALUOut every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            alu_out <= '0;
        end else begin
            if (pc_load) begin
                pc <= next_pc;
            end
            if (IRWrite) begin
                ir <= mem_rdata;
            end
            mdr     <= mem_rdata;
            alu_out <= alu_result;
        end
    end

    // Saturating debug counters for retired instructions and taken branches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count        <= '0;
            branch_taken_count <= '0;
        end else begin
            if (IRWrite && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + CNT_ONE;
            end
            if (branch_taken && (branch_taken_count != CNT_MAX)) begin
                branch_taken_count <= branch_taken_count + CNT_ONE;
            end
        end
    end

    // Fetch tracker state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_state <= IDLE;
        end else begin
            seq_state <= seq_state_nxt;
        end
    end

    // Fetch tracker next state: an IR load marks FETCHED, a later PC load clears it
    always_comb begin
        seq_state_nxt = seq_state;
        if (IRWrite) begin
            seq_state_nxt = FETCHED;
        end else if (pc_load) begin
            seq_state_nxt = IDLE;
        end
    end

    // A second IR load with no PC update since the previous one is a controller bug
    err_double_fetch: assert property (@(posedge clk) disable iff (!rst)
        !(IRWrite && (seq_state == FETCHED) && !pc_load));

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb/tb_pc_ir_unit.sv - randomized self-checking bench for pc_ir_unit
module tb_pc_ir_unit;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] JMASK = 32'h03FF_FFFF;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        BEQ_BNE;
    logic [1:0]  PCSource;
    logic        IRWrite;
    logic        IorD;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic [31:0] ir;
    logic [5:0]  Op;
    logic [31:0] mdr;
    logic [31:0] alu_out;
    logic        pc_load;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] branch_taken_count;

    int n_checks;
    int n_fail;

    logic [31:0] m_pc, m_ir, m_mdr, m_alu;
    int          m_ic, m_bc;

    pc_ir_unit #(
        .DATA_W(32), .JADDR_W(26), .RESET_PC(32'h0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .BEQ_BNE(BEQ_BNE), .PCSource(PCSource), .IRWrite(IRWrite), .IorD(IorD),
        .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
        .pc(pc), .mem_addr(mem_addr), .ir(ir), .Op(Op), .mdr(mdr),
        .alu_out(alu_out), .pc_load(pc_load), .instr_count(instr_count),
        .branch_taken_count(branch_taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_alu = 32'h0;
        m_ic = 0; m_bc = 0;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".pc"}, pc, m_pc);
        check_eq({tag, ".ir"}, ir, m_ir);
        check_eq({tag, ".op"}, {26'h0, Op}, m_ir >> 26);
        check_eq({tag, ".mdr"}, mdr, m_mdr);
        check_eq({tag, ".alu_out"}, alu_out, m_alu);
        check_eq({tag, ".instr_count"}, {24'h0, instr_count}, m_ic);
        check_eq({tag, ".branch_count"}, {24'h0, branch_taken_count}, m_bc);
    endtask

    // One controller cycle: drive strobes, check combinational outputs, clock, check registers
    task automatic cycle(input string tag, input bit irw, input bit pcw, input bit pcc,
                         input bit bb, input logic [1:0] src, input bit iord,
                         input logic [31:0] ar, input bit az, input logic [31:0] rd);
        bit          taken, load;
        logic [31:0] target;
        IRWrite = irw; PCWrite = pcw; PCWriteCond = pcc; BEQ_BNE = bb;
        PCSource = src; IorD = iord; alu_result = ar; alu_zero = az; mem_rdata = rd;
        #1;
        taken = pcc && (az != bb);
        load  = pcw || taken;
        if (src == 2'd0)      target = ar;
        else if (src == 2'd1) target = m_alu;
        else if (src == 2'd2) target = (m_pc & ~JMASK) | (m_ir & JMASK);
        else                  target = m_pc;
        check_eq({tag, ".mem_addr"}, mem_addr, iord ? m_alu : m_pc);
        check_eq({tag, ".pc_load"}, {31'h0, pc_load}, {31'h0, load});
        @(posedge clk);
        #1;
        if (load) m_pc = target;
        if (irw) begin
            m_ir = rd;
            if (m_ic < CNT_MAX) m_ic++;
        end
        if (taken && m_bc < CNT_MAX) m_bc++;
        m_mdr = rd;
        m_alu = ar;
        check_regs(tag);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0;
        PCWrite = 0; PCWriteCond = 0; BEQ_BNE = 0; PCSource = 2'd0; IRWrite = 0;
        IorD = 0; alu_result = 32'h0; alu_zero = 0; mem_rdata = 32'h0;
        model_reset();
        #12;
        check_regs("reset");
        rst = 1'b1;

        cycle("fetch", 1, 1, 0, 0, 2'd0, 0, 32'h1, 0, 32'hE400_0005);
        check_eq("fetch.ir_const", ir, 32'hE400_0005);
        check_eq("fetch.op_const", {26'h0, Op}, 32'h39);
        check_eq("fetch.pc_const", pc, 32'h1);

        cycle("setup_alu20", 0, 0, 0, 0, 2'd0, 0, 32'h20, 0, 32'h0);
        cycle("beq_nt", 0, 0, 1, 0, 2'd1, 0, 32'h20, 0, 32'h0);
        cycle("beq_t", 0, 0, 1, 0, 2'd1, 0, 32'h30, 1, 32'h0);
        check_eq("beq_t.pc_const", pc, 32'h20);
        cycle("bne_t", 0, 0, 1, 1, 2'd1, 0, 32'h30, 0, 32'h0);
        check_eq("bne_t.pc_const", pc, 32'h30);
        cycle("bne_nt", 0, 0, 1, 1, 2'd1, 0, 32'h40, 1, 32'h0);
        cycle("both_strobes", 0, 1, 1, 0, 2'd0, 0, 32'h44, 0, 32'h0);

        cycle("jmp_setup", 1, 1, 0, 0, 2'd0, 0, 32'hF000_0004, 0, 32'h0000_0123);
        cycle("jump", 0, 1, 0, 0, 2'd2, 0, 32'h0, 0, 32'h0);
        check_eq("jump.pc_const", pc, 32'hF000_0123);
        cycle("src11", 0, 1, 0, 0, 2'd3, 0, 32'h55, 0, 32'h0);

        cycle("iord_setup", 0, 0, 0, 0, 2'd0, 0, 32'h80, 0, 32'h0);
        cycle("iord", 0, 0, 0, 0, 2'd0, 1, 32'h0, 0, 32'h0000_DEAD);
        check_eq("iord.mdr_const", mdr, 32'h0000_DEAD);

        for (int i = 0; i < 300; i++) begin
            bit irw;
            irw = 1'($urandom);
            cycle("rand", irw, irw | 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom), $urandom, 1'($urandom), $urandom);
        end

        for (int i = 0; i < CNT_MAX + 4; i++)
            cycle("sat_ic", 1, 1, 0, 0, 2'd0, 0, $urandom, 0, $urandom);
        check_eq("sat_ic.const", {24'h0, instr_count}, CNT_MAX);
        for (int i = 0; i < CNT_MAX + 4; i++)
            cycle("sat_bc", 0, 0, 1, 0, 2'd0, 0, $urandom, 1, $urandom);
        check_eq("sat_bc.const", {24'h0, branch_taken_count}, CNT_MAX);

        cycle("pre_rst", 1, 1, 0, 0, 2'd0, 0, 32'h40, 0, 32'h1234_5678);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs("mid_rst");
        #3;
        rst = 1'b1;
        cycle("post_rst", 1, 1, 0, 0, 2'd0, 0, 32'h4, 0, 32'hABCD_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
